// File: rtl/risc_controller_if.sv
// risc_controller_if: control bundle between the SRM controller and its datapath.
//   master (controller): drives all datapath/PC/memory controls, reads mdata.
//   slave  (datapath)  : drives mdata, reads all controls.
//   mdata                        memory read data (instruction source for IR)
//   readnum/writenum/write       register-file access
//   vsel                         one-hot write-back select (mdata, sximm8, PC, C)
//   loada/loadb/loadc/loads      A/B/C/status register loads
//   asel/bsel/shift/ALUop        ALU operand and operation selects
//   sximm5/sximm8                sign-extended IR immediates
//   load_pc/reset_pc/addr_sel/load_addr/mem_cmd  fetch and memory sequencing
//   halted                       controller is in HALT
interface risc_controller_if;
    logic [15:0] mdata;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic [3:0]  vsel;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [15:0] sximm5;
    logic [15:0] sximm8;
    logic        load_pc;
    logic        reset_pc;
    logic        addr_sel;
    logic        load_addr;
    logic [1:0]  mem_cmd;
    logic        halted;

    modport master (
        input  mdata,
        output readnum, writenum, write, vsel,
        output loada, loadb, loadc, loads,
        output asel, bsel, shift, ALUop, sximm5, sximm8,
        output load_pc, reset_pc, addr_sel, load_addr, mem_cmd, halted
    );

    modport slave (
        output mdata,
        input  readnum, writenum, write, vsel,
        input  loada, loadb, loadc, loads,
        input  asel, bsel, shift, ALUop, sximm5, sximm8,
        input  load_pc, reset_pc, addr_sel, load_addr, mem_cmd, halted
    );
endinterface

// File: rtl/risc_controller.sv
// risc_controller: SRM control unit. Holds the instruction register, decodes it
// and runs a Moore FSM sequencing fetch, execute, load/store and halt.
//   clk    rising-edge clock
//   reset  synchronous active-high reset (forces RST, clears IR, overrides HALT)
//   bus    risc_controller_if.master: mdata in, all datapath/PC/memory controls out
module risc_controller (
    input  logic                     clk,
    input  logic                     reset,
    risc_controller_if.master        bus
);

    typedef enum logic [4:0] {
        S_RST, S_IF1, S_IF2, S_UPC, S_DEC,
        S_WIMM, S_GETA, S_GETB, S_ALU, S_CMPS, S_WRC,
        S_ADDR, S_LDA, S_MRD, S_WRM, S_GETBD, S_PASS, S_MWR,
        S_HALT
    } state_t;

    localparam logic [4:0] I_MOVI = 5'b11010;
    localparam logic [4:0] I_MOVR = 5'b11000;
    localparam logic [4:0] I_ADD  = 5'b10100;
    localparam logic [4:0] I_CMP  = 5'b10101;
    localparam logic [4:0] I_AND  = 5'b10110;
    localparam logic [4:0] I_MVN  = 5'b10111;
    localparam logic [4:0] I_LDR  = 5'b01100;
    localparam logic [4:0] I_STR  = 5'b10000;

    state_t      state, next_state;
    logic [15:0] ir;
    logic        load_ir;

    logic [2:0]  opcode;
    logic [1:0]  op;
    logic [4:0]  instr;
    logic [2:0]  rn, rd, rm;
    logic [1:0]  sh;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign instr  = {opcode, op};
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];

    assign bus.sximm5 = {{11{ir[4]}}, ir[4:0]};
    assign bus.sximm8 = {{8{ir[7]}}, ir[7:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_RST;
            ir    <= '0;
        end else begin
            state <= next_state;
            if (load_ir)
                ir <= bus.mdata;
        end
    end

    always_comb begin
        next_state    = state;
        load_ir       = 1'b0;
        bus.readnum   = '0;
        bus.writenum  = '0;
        bus.write     = 1'b0;
        bus.vsel      = 4'b0001;
        bus.loada     = 1'b0;
        bus.loadb     = 1'b0;
        bus.loadc     = 1'b0;
        bus.loads     = 1'b0;
        bus.asel      = 1'b0;
        bus.bsel      = 1'b0;
        bus.shift     = 2'b00;
        bus.ALUop     = 2'b00;
        bus.load_pc   = 1'b0;
        bus.reset_pc  = 1'b0;
        bus.addr_sel  = 1'b0;
        bus.load_addr = 1'b0;
        bus.mem_cmd   = 2'b00;
        bus.halted    = 1'b0;

        unique case (state)
            S_RST: begin
                bus.reset_pc = 1'b1;
                bus.load_pc  = 1'b1;
                next_state   = S_IF1;
            end
            S_IF1: begin
                bus.addr_sel = 1'b1;
                bus.mem_cmd  = 2'b01;
                next_state   = S_IF2;
            end
            S_IF2: begin
                bus.addr_sel = 1'b1;
                bus.mem_cmd  = 2'b01;
                load_ir      = 1'b1;
                next_state   = S_UPC;
            end
            S_UPC: begin
                bus.load_pc = 1'b1;
                next_state  = S_DEC;
            end
            S_DEC: begin
                case (instr)
                    I_MOVI:                         next_state = S_WIMM;
                    I_MOVR, I_MVN:                  next_state = S_GETB;
                    I_ADD, I_AND, I_CMP,
                    I_LDR, I_STR:                   next_state = S_GETA;
                    default:                        next_state = S_HALT;
                endcase
            end
            S_WIMM: begin
                bus.vsel     = 4'b0100;
                bus.writenum = rn;
                bus.write    = 1'b1;
                next_state   = S_IF1;
            end
            S_GETA: begin
                bus.readnum = rn;
                bus.loada   = 1'b1;
                // ALU-class ops continue to B; LDR/STR go to address generation
                next_state  = (opcode == 3'b101) ? S_GETB : S_ADDR;
            end
            S_GETB: begin
                bus.readnum = rm;
                bus.loadb   = 1'b1;
                next_state  = (instr == I_CMP) ? S_CMPS : S_ALU;
            end
            S_ALU: begin
                // op field already equals the ALU code for MOV reg (00), ADD, AND, MVN (11)
                bus.shift  = sh;
                bus.ALUop  = op;
                bus.asel   = (opcode == 3'b110);
                bus.loadc  = 1'b1;
                next_state = S_WRC;
            end
            S_CMPS: begin
                bus.shift  = sh;
                bus.ALUop  = 2'b01;
                bus.loads  = 1'b1;
                next_state = S_IF1;
            end
            S_WRC: begin
                bus.writenum = rd;
                bus.write    = 1'b1;
                next_state   = S_IF1;
            end
            S_ADDR: begin
                bus.bsel   = 1'b1;
                bus.loadc  = 1'b1;
                next_state = S_LDA;
            end
            S_LDA: begin
                bus.load_addr = 1'b1;
                next_state    = (opcode == 3'b011) ? S_MRD : S_GETBD;
            end
            S_MRD: begin
                bus.mem_cmd = 2'b01;
                next_state  = S_WRM;
            end
            S_WRM: begin
                bus.mem_cmd  = 2'b01;
                bus.vsel     = 4'b1000;
                bus.writenum = rd;
                bus.write    = 1'b1;
                next_state   = S_IF1;
            end
            S_GETBD: begin
                bus.readnum = rd;
                bus.loadb   = 1'b1;
                next_state  = S_PASS;
            end
            S_PASS: begin
                bus.asel   = 1'b1;
                bus.loadc  = 1'b1;
                next_state = S_MWR;
            end
            S_MWR: begin
                bus.mem_cmd = 2'b10;
                next_state  = S_IF1;
            end
            S_HALT: begin
                bus.halted = 1'b1;
                next_state = S_HALT;
            end
            default: next_state = S_RST;
        endcase
    end

endmodule

// File: tb/tb_risc_controller.sv
// tb_risc_controller: drives directed and random instructions into
// risc_controller and compares every cycle's control outputs against an
// instruction-level reference that lists the expected per-cycle controls.
module tb_risc_controller;

    typedef struct packed {
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic [3:0] vsel;
        logic       loada;
        logic       loadb;
        logic       asel;
        logic       bsel;
        logic [1:0] shift;
        logic [1:0] aluop;
        logic       loadc;
        logic       loads;
        logic       load_pc;
        logic       reset_pc;
        logic       addr_sel;
        logic       load_addr;
        logic [1:0] mem_cmd;
        logic       halted;
    } ctl_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    risc_controller_if bus();

    risc_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    ctl_t  exp_q[$];
    string tag_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic ctl_t idle();
        ctl_t c;
        c      = '0;
        c.vsel = 4'b0001;
        return c;
    endfunction

    function automatic ctl_t observed();
        ctl_t c;
        c.readnum   = bus.readnum;
        c.writenum  = bus.writenum;
        c.write     = bus.write;
        c.vsel      = bus.vsel;
        c.loada     = bus.loada;
        c.loadb     = bus.loadb;
        c.asel      = bus.asel;
        c.bsel      = bus.bsel;
        c.shift     = bus.shift;
        c.aluop     = bus.ALUop;
        c.loadc     = bus.loadc;
        c.loads     = bus.loads;
        c.load_pc   = bus.load_pc;
        c.reset_pc  = bus.reset_pc;
        c.addr_sel  = bus.addr_sel;
        c.load_addr = bus.load_addr;
        c.mem_cmd   = bus.mem_cmd;
        c.halted    = bus.halted;
        return c;
    endfunction

    function automatic void push(input string tag, input ctl_t c);
        exp_q.push_back(c);
        tag_q.push_back(tag);
    endfunction

    function automatic bit is_defined(input logic [15:0] ir);
        logic [4:0] k;
        k = ir[15:11];
        return (k == 5'b11010 || k == 5'b11000 || k == 5'b10100 || k == 5'b10110 ||
                k == 5'b10101 || k == 5'b10111 || k == 5'b01100 || k == 5'b10000);
    endfunction

    // Expected controls for one instruction, one entry per cycle from IF1 on.
    function automatic void plan(input logic [15:0] ir, input int unsigned halt_cycles);
        logic [2:0] rn, rd, rm;
        logic [1:0] sh, op;
        ctl_t c, ga, gb, wrc, addr, lda;
        rn = ir[10:8];
        rd = ir[7:5];
        sh = ir[4:3];
        rm = ir[2:0];
        op = ir[12:11];

        c = idle(); c.addr_sel = 1'b1; c.mem_cmd = 2'b01;
        push("IF1", c);
        push("IF2", c);
        c = idle(); c.load_pc = 1'b1;
        push("UPC", c);
        push("DEC", idle());

        ga   = idle(); ga.readnum = rn; ga.loada = 1'b1;
        gb   = idle(); gb.readnum = rm; gb.loadb = 1'b1;
        wrc  = idle(); wrc.writenum = rd; wrc.write = 1'b1;
        addr = idle(); addr.bsel = 1'b1; addr.loadc = 1'b1;
        lda  = idle(); lda.load_addr = 1'b1;

        case (ir[15:11])
            5'b11010: begin
                c = idle(); c.vsel = 4'b0100; c.writenum = rn; c.write = 1'b1;
                push("WIMM", c);
            end
            5'b11000: begin
                push("GETB", gb);
                c = idle(); c.asel = 1'b1; c.shift = sh; c.loadc = 1'b1;
                push("ALU", c);
                push("WRC", wrc);
            end
            5'b10100, 5'b10110: begin
                push("GETA", ga);
                push("GETB", gb);
                c = idle(); c.aluop = op; c.shift = sh; c.loadc = 1'b1;
                push("ALU", c);
                push("WRC", wrc);
            end
            5'b10101: begin
                push("GETA", ga);
                push("GETB", gb);
                c = idle(); c.aluop = 2'b01; c.shift = sh; c.loads = 1'b1;
                push("CMPS", c);
            end
            5'b10111: begin
                push("GETB", gb);
                c = idle(); c.aluop = 2'b11; c.shift = sh; c.loadc = 1'b1;
                push("ALU", c);
                push("WRC", wrc);
            end
            5'b01100: begin
                push("GETA", ga);
                push("ADDR", addr);
                push("LDA", lda);
                c = idle(); c.mem_cmd = 2'b01;
                push("MRD", c);
                c.vsel = 4'b1000; c.writenum = rd; c.write = 1'b1;
                push("WRM", c);
            end
            5'b10000: begin
                push("GETA", ga);
                push("ADDR", addr);
                push("LDA", lda);
                c = idle(); c.readnum = rd; c.loadb = 1'b1;
                push("GETBD", c);
                c = idle(); c.asel = 1'b1; c.loadc = 1'b1;
                push("PASS", c);
                c = idle(); c.mem_cmd = 2'b10;
                push("MWR", c);
            end
            default: begin
                c = idle(); c.halted = 1'b1;
                for (int unsigned i = 0; i < halt_cycles; i++)
                    push("HALT", c);
            end
        endcase
    endfunction

    // Entered at a negedge whose following posedge moves the DUT into IF1.
    task automatic run(input logic [15:0] ir, input int unsigned max_cycles);
        int unsigned k;
        string       tag;
        ctl_t        e;
        bus.mdata = ir;
        plan(ir, 20);
        k = 0;
        while (exp_q.size() > 0 && k < max_cycles) begin
            @(posedge clk);
            @(negedge clk);
            e   = exp_q.pop_front();
            tag = tag_q.pop_front();
            check($sformatf("%h %s c%0d", ir, tag, k), 64'(observed()), 64'(e));
            if (k == 3) begin
                check($sformatf("%h sximm5", ir), 64'(bus.sximm5), 64'({{11{ir[4]}}, ir[4:0]}));
                check($sformatf("%h sximm8", ir), 64'(bus.sximm8), 64'({{8{ir[7]}}, ir[7:0]}));
            end
            k++;
        end
        exp_q.delete();
        tag_q.delete();
    endtask

    task automatic do_reset(input string tag);
        ctl_t e;
        e = idle(); e.reset_pc = 1'b1; e.load_pc = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({tag, " RST"}, 64'(observed()), 64'(e));
        check({tag, " IR clear"}, 64'(bus.sximm8), 64'(0));
        reset = 1'b0;
    endtask

    function automatic logic [15:0] rand_instr();
        logic [4:0]  codes [8] = '{5'b11010, 5'b11000, 5'b10100, 5'b10110,
                                   5'b10101, 5'b10111, 5'b01100, 5'b10000};
        logic [15:0] r;
        int unsigned k;
        r = 16'($urandom);
        k = $urandom_range(0, 17);
        if (k < 16)       r[15:11] = codes[k % 8];
        else if (k == 16) r[15:13] = 3'b111;
        else              r[15:11] = 5'b11001;
        return r;
    endfunction

    initial begin
        logic [15:0] ir;
        bus.mdata = '0;

        do_reset("init");

        run(16'hD007, 100);
        run(16'hA148, 100);
        run(16'hA900, 100);
        run(16'h6162, 100);
        run(16'h817F, 100);

        // Reset during GETB of an ADD: next cycle must be RST, never WRC.
        run(16'hA148, 6);
        do_reset("midADD");

        run(16'hE000, 100);
        do_reset("halt");

        for (int unsigned n = 0; n < 150; n++) begin
            ir = rand_instr();
            run(ir, 100);
            if (!is_defined(ir))
                do_reset("rhalt");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/risc_controller.md
Name: risc_controller

Overview:
- Control end of the SRM datapath: holds the instruction register, decodes it, and runs a Moore FSM.
- Drives every datapath control input (readnum, writenum, write, vsel, loada, loadb, asel, bsel, shift, ALUop, loadc, loads) and sximm5/sximm8.
- Also drives the PC/address/memory-command controls that sequence fetch, execute, load/store and halt.

Parameters:
- none (widths fixed by ISA: 16-bit instruction, 3-bit register numbers).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- mdata  in  16  memory read data (instruction fetched into IR)
- readnum  out  3  register-file read index
- writenum  out  3  register-file write index
- write  out  1  register-file write enable
- vsel  out  4  one-hot write-back select: 1000 mdata, 0100 sximm8, 0010 {8'b0,PC}, 0001 C
- loada, loadb, loadc, loads  out  1 each  A/B/C/status register load enables
- asel  out  1  1 selects 16'b0 for Ain; 0 selects A
- bsel  out  1  1 selects sximm5 for Bin; 0 selects shifter output
- shift  out  2  00 none, 01 LSL1, 10 LSR1, 11 ASR1
- ALUop  out  2  00 add, 01 sub, 10 and, 11 not-B
- sximm5  out  16  sign-extended IR[4:0]
- sximm8  out  16  sign-extended IR[7:0]
- load_pc, reset_pc  out  1 each  PC load enable; PC next-value select (1 gives 0, 0 gives PC+1)
- addr_sel  out  1  1 gives memory address from PC; 0 from data-address register
- load_addr  out  1  data-address register loads C[8:0]
- mem_cmd  out  2  00 none, 01 read, 10 write
- halted  out  1  high in HALT state

Behaviour:
- Fixed fields:
  - IR is loaded from mdata only when load_ir (internal) is high; opcode=IR[15:13], op=IR[12:11].
  - Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
  - sximm5/sximm8 are combinational from IR.
- Default outputs: all enables 0, vsel=0001, shift=00, ALUop=00, readnum=writenum=0, mem_cmd=00. States below list only deviations. Outputs depend on state and IR only.
- Reset: edge with reset=1 forces state RST and IR=16'h0000 regardless of the current state. Any in-flight instruction is aborted with no further write, load or mem_cmd. Reset overrides HALT.
- Fetch states:
  - RST: reset_pc=1, load_pc=1 -> IF1.
  - IF1: addr_sel=1, mem_cmd=01 -> IF2.
  - IF2: addr_sel=1, mem_cmd=01, load_ir=1 -> UPC.
  - UPC: load_pc=1 -> DEC.
  - DEC: no outputs; dispatch on {opcode,op}.
- MOV Rn,#im8 (110,10): WIMM (vsel=0100, writenum=Rn, write=1) -> IF1.
- MOV Rd,Rm,sh (110,00): GETB -> ALU(asel=1, ALUop=00) -> WRC.
- ADD (101,00) and AND (101,10): GETA -> GETB -> ALU(ALUop=op) -> WRC.
- CMP (101,01): GETA -> GETB -> CMPS(ALUop=01, loads=1, loadc=0, shift=sh) -> IF1.
- MVN (101,11): GETB -> ALU(ALUop=11) -> WRC.
- Execute states:
  - GETA: readnum=Rn, loada=1.
  - GETB: readnum=Rm, loadb=1.
  - ALU: shift=sh, loadc=1.
  - WRC: vsel=0001, writenum=Rd, write=1 -> IF1.
- LDR Rd,[Rn,#im5] (011,00): GETA -> ADDR(bsel=1, ALUop=00, loadc=1) -> LDA(load_addr=1) -> MRD(addr_sel=0, mem_cmd=01) -> WRM(mem_cmd=01, vsel=1000, writenum=Rd, write=1) -> IF1.
- STR Rd,[Rn,#im5] (100,00): GETA -> ADDR -> LDA -> GETBD(readnum=Rd, loadb=1) -> PASS(asel=1, shift=00, ALUop=00, loadc=1) -> MWR(addr_sel=0, mem_cmd=10) -> IF1.
- HALT (111) or any undefined {opcode,op}: HALT state, halted=1, all controls default; stays until reset.
- Latency from IF1 to next IF1:
  - MOV imm: 5 cycles.
  - MOV reg/MVN: 7 cycles.
  - ADD/AND: 8 cycles.
  - CMP: 7 cycles.
  - LDR: 9 cycles.
  - STR: 10 cycles.
- write and mem_cmd=10 are never both high. write is never high outside WIMM/WRC/WRM.

Test Plan:
- Reset, then mdata=16'hD007 (MOV R0,#7) -> RST, IF1, IF2, UPC, DEC, WIMM. In WIMM: vsel=0100, writenum=0, write=1, sximm8=16'h0007. Next state IF1, 5 cycles after first IF1.
- mdata=16'hA148 (ADD R2,R1,R0,LSL#1) -> GETA readnum=1, GETB readnum=0, ALU shift=01/ALUop=00/loadc=1, WRC writenum=2/write=1. 8-cycle instruction.
- mdata=16'hA900 (CMP R1,R0) -> CMPS asserts loads=1, ALUop=01, loadc=0. No write in any cycle.
- mdata=16'h6162 (LDR R3,[R1,#2]) -> ADDR bsel=1, sximm5=16'h0002. LDA load_addr=1. MRD/WRM mem_cmd=01, addr_sel=0. WRM vsel=1000, writenum=3.
- mdata=16'h817F (STR R3,[R1,#-1]) -> sximm5=16'hFFFF, GETBD readnum=3, PASS asel=1, MWR mem_cmd=10/addr_sel=0, write=0 throughout.
- mdata=16'hE000 -> HALT, halted=1 held for 20 cycles. Then reset=1 for 1 cycle -> RST with reset_pc=1, halted=0. Also: reset asserted in GETB of an ADD -> next state RST, no WRC cycle occurs.
